quad_step_gen: RTL and testbench



---
 rtl/quad_step_pkg.sv | 22 ++
 rtl/hex_seg7.sv | 11 +
 rtl/quad_step_gen.sv | 134 +++++++++++++
 tb/tb_quad_step_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_step_pkg.sv
// Shared types and constant tables for the quadrature step generator:
// FSM states, A/B phase sequences and the 7-segment glyph table.
package quad_step_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // AB pairs per phase; entry 3 is the detent rest position 00.
  localparam logic [1:0] UP_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] DN_SEQ [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  // Active-high segments packed as {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/hex_seg7.sv
// Combinational hex digit to 7-segment decode, shared with the decoder block.
module hex_seg7
  import quad_step_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG7_TAB[digit];

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature A/B step generator with a position counter and hex display code.
// Contact-bounce emulation is compiled in when QUAD_BOUNCE_EN is defined.
module quad_step_gen
  import quad_step_pkg::*;
#(
  parameter int STEP_DIV = 8,
  parameter int BOUNCE_N = 3
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       step_up,
  input  logic       step_dn,
  output logic       busy,
  output logic       done,
  output logic       A,
  output logic       B,
  output logic [3:0] cnt,
  output logic [6:0] codeout
);

  localparam int DW = $clog2(STEP_DIV);
  localparam logic [DW-1:0] DWELL_MAX = DW'(STEP_DIV - 1);

  if (STEP_DIV < 2) begin : g_chk_div
    $error("quad_step_gen: STEP_DIV must be at least 2");
  end
`ifdef QUAD_BOUNCE_EN
  if (STEP_DIV <= 2 * BOUNCE_N) begin : g_chk_bounce
    $error("quad_step_gen: STEP_DIV must exceed 2*BOUNCE_N");
  end
  localparam logic [DW-1:0] BOUNCE_LEN = DW'(2 * BOUNCE_N);
`else
  if (BOUNCE_N < 0) begin : g_chk_bounce
    $error("quad_step_gen: BOUNCE_N must be non-negative");
  end
`endif

  state_t         state_r, state_s;
  logic           start_s, last_s, dir_up_r;
  logic [1:0]     phase_r, ab_s, ab_r;
  logic [DW-1:0]  dwell_r;
  logic           busy_r, done_r;
  logic [3:0]     cnt_r;

  // Next-state logic; busy_r gates the idle cycle right after a step finishes
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    last_s  = (phase_r == 2'd3) && (dwell_r == DWELL_MAX);
    case (state_r)
      IDLE: begin
        if (!busy_r && (step_up ^ step_dn)) begin
          state_s = RUN;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // A/B pattern for the current phase and dwell position
`ifdef QUAD_BOUNCE_EN
  logic [1:0] old_s;
  always_comb begin
    old_s = dir_up_r ? UP_SEQ[phase_r - 2'd1] : DN_SEQ[phase_r - 2'd1];
    if ((dwell_r < BOUNCE_LEN) && dwell_r[0]) begin
      ab_s = old_s;
    end else begin
      ab_s = dir_up_r ? UP_SEQ[phase_r] : DN_SEQ[phase_r];
    end
  end
`else
  always_comb begin
    ab_s = dir_up_r ? UP_SEQ[phase_r] : DN_SEQ[phase_r];
  end
`endif

  // State, phase/dwell counters and registered outputs
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r  <= IDLE;
      dir_up_r <= 1'b0;
      phase_r  <= 2'd0;
      dwell_r  <= {DW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ab_r     <= 2'b00;
      cnt_r    <= 4'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_r == RUN);
      done_r  <= (state_r == RUN) && last_s;
      if (start_s) begin
        dir_up_r <= step_up;
        phase_r  <= 2'd0;
        dwell_r  <= {DW{1'b0}};
      end else if (state_r == RUN) begin
        if (dwell_r == DWELL_MAX) begin
          dwell_r <= {DW{1'b0}};
          phase_r <= phase_r + 2'd1;
        end else begin
          dwell_r <= dwell_r + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      if (state_r == RUN) begin
        ab_r <= ab_s;
      end
      if ((state_r == RUN) && last_s) begin
        cnt_r <= dir_up_r ? (cnt_r + 4'd1) : (cnt_r - 4'd1);
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign A    = ab_r[1];
  assign B    = ab_r[0];
  assign cnt  = cnt_r;

  hex_seg7 u_seg (
    .digit (cnt_r),
    .seg   (codeout)
  );

endmodule

// File: tb/tb_quad_step_gen.sv
// Scoreboard bench for quad_step_gen: the driver queues each accepted step,
// a negedge monitor checks every cycle against the queued expectation.
module tb_quad_step_gen;

  localparam int D  = 8;
  localparam int BN = 3;

  logic       clkin = 1'b0;
  logic       rst, step_up, step_dn;
  logic       busy, done, A, B;
  logic [3:0] cnt;
  logic [6:0] codeout;

  quad_step_gen #(.STEP_DIV(D), .BOUNCE_N(BN)) dut (
    .clkin   (clkin),
    .rst     (rst),
    .step_up (step_up),
    .step_dn (step_dn),
    .busy    (busy),
    .done    (done),
    .A       (A),
    .B       (B),
    .cnt     (cnt),
    .codeout (codeout)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit up;
    int t;
    int cnt;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    pushed = 0;
  int    dones_seen = 0;
  int    m_cnt = 0;
  int    m_shown = 0;
  bit    mon_en = 1'b0;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ab_of(input bit up, input int k);
    logic a, b;
    if (k < 0 || k > 3) return 2'b00;
    a = (k == 0) || (k == 1);
    b = (k == 1) || (k == 2);
    return up ? {a, b} : {b, a};
  endfunction

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // Synchronous reset discards any step in flight
  always @(posedge clkin) begin
    if (rst) begin
      pushed  = pushed - q.size();
      q.delete();
      m_shown = 0;
    end
  end

  int         mi, mk, md;
  logic [1:0] mab;
  logic       mdone;

  // Monitor: compare every cycle against the head of the scoreboard
  always @(negedge clkin) begin
    if (mon_en) begin
      if (q.size() > 0 && cyc > q[0].t) begin
        mi    = cyc - q[0].t - 1;
        mk    = mi / D;
        md    = mi % D;
        mab   = ab_of(q[0].up, mk);
`ifdef QUAD_BOUNCE_EN
        if (md < 2 * BN && (md % 2) == 1) mab = ab_of(q[0].up, mk - 1);
`endif
        mdone = (mi == 4 * D - 1);
        chk("step_ctl", 16'({busy, done, A, B}), 16'({1'b1, mdone, mab}));
        if (mdone) begin
          chk("step_cnt", 16'(cnt), 16'(q[0].cnt));
          chk("step_seg", 16'(codeout), 16'(seg_of(q[0].cnt)));
          m_shown = q[0].cnt;
          void'(q.pop_front());
          dones_seen++;
        end
      end else begin
        chk("idle_ctl", 16'({busy, done, A, B}), 16'd0);
        chk("idle_cnt", 16'(cnt), 16'(m_shown));
        chk("idle_seg", 16'(codeout), 16'(seg_of(m_shown)));
      end
    end
  end

  task automatic issue(input bit up, input bit dn);
    int w;
    w = 0;
    @(negedge clkin);
    while (busy !== 1'b0 && w < 400) begin
      @(negedge clkin);
      w++;
    end
    if (busy !== 1'b0) chk("busy_wait_timeout", 16'(busy), 16'd0);
    step_up = up;
    step_dn = dn;
    if (up ^ dn) begin
      m_cnt = (m_cnt + (up ? 1 : 15)) % 16;
      q.push_back('{up, cyc + 1, m_cnt});
      pushed++;
    end
    @(negedge clkin);
    step_up = 1'b0;
    step_dn = 1'b0;
    @(negedge clkin);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst   = 1'b1;
    m_cnt = 0;
    @(negedge clkin);
    rst   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int r;
    rst = 1'b1;
    step_up = 1'b0;
    step_dn = 1'b0;
    repeat (2) @(negedge clkin);
    chk("rst_ab",   16'({A, B}), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_cnt",  16'(cnt), 16'd0);
    chk("rst_seg",  16'(codeout), 16'(7'b0111111));
    rst = 1'b0;
    mon_en = 1'b1;

    issue(1'b1, 1'b0);
    issue(1'b0, 1'b1);
    issue(1'b0, 1'b1);

    do_reset();
    for (int i = 0; i < 17; i++) issue(1'b1, 1'b0);

    issue(1'b1, 1'b0);
    repeat (3) @(negedge clkin);
    step_up = 1'b1;
    @(negedge clkin);
    step_up = 1'b0;
    issue(1'b1, 1'b1);

    issue(1'b0, 1'b1);
    repeat (10) @(negedge clkin);
    rst   = 1'b1;
    m_cnt = 0;
    @(negedge clkin);
    rst   = 1'b0;
    issue(1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clkin);
      r = $urandom_range(0, 5);
      if (r <= 1) issue(1'b1, 1'b0);
      else if (r <= 3) issue(1'b0, 1'b1);
      else if (r == 4) issue(1'b1, 1'b1);
      else begin
        issue(1'b0, 1'b1);
        repeat ($urandom_range(1, 20)) @(negedge clkin);
        step_up = 1'b1;
        @(negedge clkin);
        step_up = 1'b0;
      end
    end

    w = 0;
    while (q.size() > 0 && w < 400) begin
      @(negedge clkin);
      w++;
    end
    repeat (2) @(negedge clkin);
    chk("queue_drained", 16'(q.size()), 16'd0);
    chk("done_count", 16'(dones_seen), 16'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
